// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, FSM state types and baud divisor helper
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop input synchronizer and mid-bit sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    rx_state_t state;
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] shift;
    logic rx_s;
    assign rx_s = sync[1];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync         <= 2'b11;
            state        <= RX_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            sync         <= {sync[0], rx};
            rx_frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rx_s) state <= RX_IDLE;
                        else begin
                            state    <= RX_DATA;
                            rx_valid <= 1'b0;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                RX_DATA: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                        if (idx == IW'(DATA_BITS - 1)) state <= RX_STOP;
                    end else cnt <= cnt + 1'b1;
                end
                RX_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end else rx_frame_err <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART with receiver sub-module and inline transmitter
// transmitter present only when UART_TX_EN is defined; otherwise tx idles high
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 9600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );
`ifdef UART_TX_EN
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    tx_state_t tx_state;
    logic [CW-1:0] tx_cnt;
    logic [3:0] tx_idx;
    logic [DATA_BITS+STOP_BITS-1:0] tx_shift;
    assign tx_busy = (tx_state == TX_SEND);
    // tx_shift holds the bits still to go after the one currently on the line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (tx_start) begin
                tx_state <= TX_SEND;
                tx_shift <= {{STOP_BITS{1'b1}}, tx_data};
                tx_cnt   <= '0;
                tx_idx   <= '0;
                tx       <= 1'b0;
            end
        end else if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 4'(FRAME_BITS - 1)) begin
                tx_state <= TX_IDLE;
                tx       <= 1'b1;
            end else begin
                tx_idx   <= tx_idx + 1'b1;
                tx       <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[DATA_BITS+STOP_BITS-1:1]};
            end
        end else tx_cnt <= tx_cnt + 1'b1;
    end
`else
    logic unused_tx;
    assign unused_tx = ^{tx_data, tx_start};
    assign tx        = 1'b1;
    assign tx_busy   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed self-checking bench for uart_core at a scaled baud divisor
module tb_uart_core;
    import uart_pkg::*;
    localparam int CLK_HZ = 1000;
    localparam int BAUD_R = 60;
    localparam int CPB    = 17;
    logic clk = 0, rst_n = 0, rx_drv = 1, loop = 0, tx_start = 0;
    logic rx_line, tx, rx_valid, rx_frame_err, tx_busy;
    logic [7:0] rx_byte, tx_data = 8'h00;
    int checks = 0, errors = 0, cyc = 0, start_cyc = 0, rise_cyc = 0;
    int ferr_cycles = 0, ferr_pulses = 0;
    logic prev_valid = 0, prev_ferr = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_b[4] = '{8'hAB, 8'hFF, 8'h00, 8'h12};
    assign rx_line = loop ? tx : rx_drv;
    always #5 clk = ~clk;
    uart_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx_line),
        .tx           (tx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy)
    );
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            got_q.push_back(rx_byte);
            rise_cyc <= cyc;
        end
        if (rx_frame_err) ferr_cycles <= ferr_cycles + 1;
        if (rx_frame_err && !prev_ferr) ferr_pulses <= ferr_pulses + 1;
        prev_valid <= rx_valid;
        prev_ferr  <= rx_frame_err;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_drv = f[i];
            if (i == 0) start_cyc = cyc;
            repeat (CPB - 1) @(negedge clk);
        end
    endtask
    function automatic logic [7:0] last_byte();
        return (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx;
    endfunction
    initial begin
        int n;
        logic saw_low, saw_busy;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", rx_frame_err, 0);
        check("rst_tx_busy", tx_busy, 0);
        rst_n = 1;
        repeat (5) @(negedge clk);
        send_byte(8'hAB, 1);
        send_byte(8'hFF, 1);
        send_byte(8'h00, 1);
        send_byte(8'h12, 1);
        repeat (2 * CPB) @(negedge clk);
        check("b2b_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
        check("b2b_valid", rx_valid, 1);
        check("b2b_ferr", ferr_pulses, 0);
        check("b2b_latency_in_bound", (rise_cyc - start_cyc >= 9 * CPB) && (rise_cyc - start_cyc <= 164), 1);
        @(negedge clk);
        rx_drv = 0;
        repeat (3) @(negedge clk);
        rx_drv = 1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_count", got_q.size(), 4);
        check("glitch_ferr", ferr_pulses, 0);
        check("glitch_valid", rx_valid, 1);
        check("glitch_byte", rx_byte, 8'h12);
        check("glitch_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));
        send_byte(8'h5A, 0);
        @(negedge clk);
        rx_drv = 1;
        repeat (3 * CPB) @(negedge clk);
        check("ferr_pulses", ferr_pulses, 1);
        check("ferr_width", ferr_cycles, 1);
        check("ferr_valid", rx_valid, 0);
        check("ferr_byte", rx_byte, 8'h12);
        check("ferr_count", got_q.size(), 4);
        @(negedge clk);
        rx_drv = 0;
        repeat (3 * CPB) @(negedge clk);
        rst_n  = 0;
        rx_drv = 1;
        repeat (3) @(negedge clk);
        check("midrst_byte", rx_byte, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));
        rst_n = 1;
        repeat (CPB) @(negedge clk);
        send_byte(8'h3C, 1);
        repeat (2 * CPB) @(negedge clk);
        check("midrst_count", got_q.size(), 5);
        check("midrst_last", last_byte(), 8'h3C);
        check("midrst_valid_after", rx_valid, 1);
        check("midrst_ferr", ferr_pulses, 1);
`ifdef UART_TX_EN
        loop = 1;
        @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1;
        @(negedge clk);
        tx_start = 0;
        n = 0;
        while (tx_busy && n < 2000) begin
            n++;
            if (n == 50) begin
                tx_data  = 8'hFF;
                tx_start = 1;
            end else tx_start = 0;
            @(negedge clk);
        end
        tx_start = 0;
        check("tx_busy_cycles", n, 10 * CPB);
        repeat (CPB) @(negedge clk);
        check("tx_loop_count", got_q.size(), 6);
        check("tx_loop_byte", rx_byte, 8'h55);
        check("tx_loop_valid", rx_valid, 1);
        check("tx_idle_high", tx, 1);
`else
        saw_low  = 0;
        saw_busy = 0;
        @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1;
        @(negedge clk);
        tx_start = 0;
        for (int i = 0; i < 50; i++) begin
            if (!tx) saw_low = 1;
            if (tx_busy) saw_busy = 1;
            @(negedge clk);
        end
        check("notx_tx_low", saw_low, 0);
        check("notx_busy", saw_busy, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, meaning system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, meaning line bit rate.
REQ-003 Derived localparam CLKS_PER_BIT SHALL equal round(CLK_FREQ_HZ/BAUD), which is 10417 at the defaults.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 rx  input  1  asynchronous serial input; idles high.
REQ-007 tx  output  1  serial output; idles high.
REQ-008 rx_byte  output  8  last received data byte.
REQ-009 rx_valid  output  1  high while rx_byte holds a fresh byte.
REQ-010 rx_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 tx_data  input  8  byte to transmit.
REQ-012 tx_start  input  1  transmit request, accepted only when tx_busy is 0.
REQ-013 tx_busy  output  1  transmitter occupied.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, then 8 data bits LSB first, then stop bit 1.
REQ-015 rx SHALL pass a 2-flop synchronizer before use; all receiver decisions use the synchronized value.
REQ-016 Receiver states SHALL be IDLE, START, DATA and STOP.
REQ-017 IDLE -> START on synchronized rx = 0.
REQ-018 In START, at CLKS_PER_BIT/2 cycles, rx = 0 -> DATA; rx = 1 -> IDLE (glitch rejected, no output change).
REQ-019 In DATA, one bit SHALL be sampled every CLKS_PER_BIT cycles at mid-bit into rx_byte[i], i = 0..7.
REQ-020 After bit 7 the receiver SHALL enter STOP and sample the stop bit one bit period later.
REQ-021 Stop = 1: rx_byte updated and rx_valid set to 1 in the same cycle.
REQ-022 Stop = 0: rx_frame_err pulses for one cycle, rx_byte and rx_valid unchanged.
REQ-023 After STOP the receiver SHALL return to IDLE immediately, so a back-to-back start bit is caught.
REQ-024 rx_valid SHALL remain 1 until the next start bit is accepted in START, then clear to 0, giving exactly one rising edge per good byte.
REQ-025 Receive latency SHALL be at most 9.5 bit periods plus 3 clocks from the start-bit falling edge to rx_valid rising.
REQ-026 Transmitter: tx_start with tx_busy = 0 latches tx_data and raises tx_busy on the next clock.
REQ-027 Transmitter SHALL drive 10 bit periods of CLKS_PER_BIT cycles each; tx_busy falls in the cycle after the stop bit ends.
REQ-028 tx_start while tx_busy = 1 SHALL be ignored.

Reset
REQ-029 While rst_n = 0 at a clk edge: both FSMs go to IDLE, all counters reset to 0, tx = 1, rx_byte = 0x00, rx_valid = 0, rx_frame_err = 0, tx_busy = 0, and synchronizer flops = 1.
REQ-030 Reset mid-frame SHALL abort the frame with no rx_valid or rx_frame_err.

Configuration
REQ-031 Macro UART_TX_EN defined: transmitter is present as specified.
REQ-032 Macro UART_TX_EN undefined: transmitter logic is absent, tx is tied to 1, tx_busy is tied to 0, tx_data and tx_start are ignored, and the receiver is unchanged.

Structure
REQ-033 Package uart_pkg SHALL hold the receiver/transmitter state enum typedefs and the frame constants DATA_BITS = 8 and STOP_BITS = 1.
REQ-034 The receiver SHALL be a sub-module uart_rx instantiated by uart_core; the transmitter stays inline.

Verification
REQ-035 Send 0xAB, 0xFF, 0x00, 0x12 back-to-back at 9600 baud -> four rx_valid rising edges, with rx_byte = AB, FF, 00, 12 in order.
REQ-036 Drive a 2000-cycle low glitch on idle rx -> no rx_valid, no rx_frame_err, receiver back in IDLE.
REQ-037 Send 0x5A with stop bit = 0 -> one-cycle rx_frame_err, rx_valid stays 0, rx_byte unchanged.
REQ-038 Assert rst_n = 0 mid-frame, release, then send 0x3C -> only 0x3C is reported.
REQ-039 With UART_TX_EN, pulse tx_start with tx_data = 0x55 and loop tx back to rx -> tx_busy high for 104170 cycles, then rx_byte = 0x55 with rx_valid = 1.
REQ-040 Without UART_TX_EN, pulse tx_start -> tx stays 1 and tx_busy stays 0.
